// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifu_state_e;

  localparam int          IFU_DEPTH_DEFAULT    = 4;
  localparam logic [31:0] IFU_RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] IFU_WORD_INC         = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: redirect input, instruction-memory port and controller port.
interface instruction_fetch_unit_if;

  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        memReqValid;
  logic [31:0] memReqAddr;
  logic        memReqReady;
  logic        memRespValid;
  logic [31:0] memRespData;
  logic        instrValid;
  logic [31:0] instruction;
  logic [31:0] instrPC;
  logic        instrReady;

  modport master (
    input  redirectValid, redirectTarget, memReqReady, memRespValid, memRespData, instrReady,
    output memReqValid, memReqAddr, instrValid, instruction, instrPC
  );

  modport slave (
    output redirectValid, redirectTarget, memReqReady, memRespValid, memRespData, instrReady,
    input  memReqValid, memReqAddr, instrValid, instruction, instrPC
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries; flush clears pointers and count.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clock,
  input  logic          resetN,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [63:0]   push_data,
  output logic [63:0]   head_data,
  output logic [CW-1:0] count
);

  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are hidden behind count==0.
  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding an instruction queue.
//  state | meaning
//  REQ   | present a fetch request when the queue has room
//  WAIT  | one request accepted, waiting for its response
//  DROP  | redirected while waiting; discard the next response
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = IFU_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = IFU_RESET_PC_DEFAULT
) (
  input  logic                      clock,
  input  logic                      resetN,
  instruction_fetch_unit_if.master  bus
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  ifu_state_e    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;

  logic          req_valid;
  logic          push, pop, flush;
  logic [63:0]   head_data;
  logic [CW-1:0] count;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    flush      = bus.redirectValid;
    req_valid  = resetN && (state_q == REQ) && (count < DEPTH_C) && !bus.redirectValid;
    pop        = (count != '0) && bus.instrReady && !bus.redirectValid;

    case (state_q)
      REQ: begin
        if (bus.redirectValid) begin
          fetch_pc_d = word_align(bus.redirectTarget);
        end else if (req_valid && bus.memReqReady) begin
          state_d    = WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + IFU_WORD_INC;
        end
      end
      WAIT: begin
        if (bus.redirectValid) begin
          fetch_pc_d = word_align(bus.redirectTarget);
          state_d    = bus.memRespValid ? REQ : DROP;
        end else if (bus.memRespValid) begin
          push    = 1'b1;
          state_d = REQ;
        end
      end
      DROP: begin
        if (bus.redirectValid) fetch_pc_d = word_align(bus.redirectTarget);
        if (bus.memRespValid)  state_d    = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= REQ;
      fetch_pc_q <= word_align(RESET_PC);
      req_pc_q   <= word_align(RESET_PC);
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetN    (resetN),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data ({req_pc_q, bus.memRespData}),
    .head_data (head_data),
    .count     (count)
  );

  assign bus.memReqValid = req_valid;
  assign bus.memReqAddr  = word_align(fetch_pc_q);
  assign bus.instrValid  = (count != '0);
  assign bus.instrPC     = head_data[63:32];
  assign bus.instruction = head_data[31:0];

endmodule
